// File: rtl/pmos_switch_model_if.sv
`default_nettype none
// ============================================================================
// Module      : pmos_switch_model_if
// Description : Signal bundle for the clocked PMOS switch model. The master
//               side drives the sampled terminals and the statistics clear;
//               the slave side (the switch model) returns the resolved drain,
//               drive enable, effective width and diagnostics.
// Ports       : g, s, bulk   - 2-bit encoded terminals (00=0,01=1,10=Z,11=X)
//               stat_clr     - synchronous clear of counters and sticky flags
//               d, d_drive   - registered drain value and drive enable
//               weff         - W*M*NF effective width (64 bits)
//               bulk_err, x_err, stat_on, stat_tog - diagnostics
// Revision    : 1.0 - initial release
// ============================================================================
interface pmos_switch_model_if;
  logic [1:0]  g;
  logic [1:0]  s;
  logic [1:0]  bulk;
  logic        stat_clr;
  logic [1:0]  d;
  logic        d_drive;
  logic [63:0] weff;
  logic        bulk_err;
  logic        x_err;
  logic [31:0] stat_on;
  logic [31:0] stat_tog;

  modport master (
    output g, s, bulk, stat_clr,
    input  d, d_drive, weff, bulk_err, x_err, stat_on, stat_tog
  );

  modport slave (
    input  g, s, bulk, stat_clr,
    output d, d_drive, weff, bulk_err, x_err, stat_on, stat_tog
  );
endinterface
`default_nettype wire

// File: rtl/pmos_switch_model.sv
`default_nettype none
// ============================================================================
// Module      : pmos_switch_model
// Description : Clocked behavioural model of one PMOS pass transistor. Gate
//               and source are sampled every rising clk edge and the resolved
//               drain is registered with its drive enable. Optional diagnostic
//               counters and sticky flags exist when DEBUG == "true".
// Ports       : clk    - sampling clock
//               reset  - asynchronous active-high reset
//               bus    - pmos_switch_model_if.slave (terminals, drain, stats)
// Revision    : 1.0 - initial release
// ============================================================================
module pmos_switch_model #(
  parameter string       DEBUG = "true",
  parameter int unsigned W     = 0,
  parameter int unsigned L     = 0,
  parameter int unsigned M     = 0,
  parameter int unsigned NF    = 0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pmos_switch_model_if.slave   bus
);

  localparam logic        DEBUG_EN = (DEBUG == "true");
  localparam logic [1:0]  V0       = 2'b00;
  localparam logic [1:0]  V1       = 2'b01;
  localparam logic [1:0]  VZ       = 2'b10;
  localparam logic [1:0]  VX       = 2'b11;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  logic [1:0]  d_q,        d_d;
  logic        drive_q,    drive_d;
  logic        bulk_err_q, bulk_err_d;
  logic        x_err_q,    x_err_d;
  logic [31:0] stat_on_q,  stat_on_d;
  logic [31:0] stat_tog_q, stat_tog_d;

  // Length is carried for reporting only; fold it into a sink net.
  logic unused_len;
  assign unused_len = ^L;

  // Channel resolution. A conducting gate passes the source unchanged, so a
  // Z or X source propagates as-is. An unknown gate can only leave the
  // drain floating when there is nothing to pass.
  always_comb begin
    d_d = VZ;
    case (bus.g)
      V0:      d_d = bus.s;
      V1:      d_d = VZ;
      default: d_d = (bus.s == VZ) ? VZ : VX;
    endcase
    drive_d = (d_d != VZ);
  end

  // Diagnostics: clear wins over same-cycle increment/set, and the whole
  // block collapses to constant zero when debug is disabled.
  always_comb begin
    stat_on_d  = stat_on_q;
    stat_tog_d = stat_tog_q;
    bulk_err_d = bulk_err_q | (bus.bulk != V1);
    x_err_d    = x_err_q | (d_d == VX);
    if ((bus.g == V0) && (stat_on_q != CNT_MAX)) begin
      stat_on_d = stat_on_q + 32'd1;
    end
    if ((d_d != d_q) && (stat_tog_q != CNT_MAX)) begin
      stat_tog_d = stat_tog_q + 32'd1;
    end
    if (bus.stat_clr || !DEBUG_EN) begin
      stat_on_d  = '0;
      stat_tog_d = '0;
      bulk_err_d = 1'b0;
      x_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q        <= VZ;
      drive_q    <= 1'b0;
      bulk_err_q <= 1'b0;
      x_err_q    <= 1'b0;
      stat_on_q  <= '0;
      stat_tog_q <= '0;
    end else begin
      d_q        <= d_d;
      drive_q    <= drive_d;
      bulk_err_q <= bulk_err_d;
      x_err_q    <= x_err_d;
      stat_on_q  <= stat_on_d;
      stat_tog_q <= stat_tog_d;
    end
  end

  assign bus.d        = d_q;
  assign bus.d_drive  = drive_q;
  assign bus.bulk_err = bulk_err_q;
  assign bus.x_err    = x_err_q;
  assign bus.stat_on  = stat_on_q;
  assign bus.stat_tog = stat_tog_q;
  assign bus.weff     = 64'(W) * 64'(M) * 64'(NF);

endmodule
`default_nettype wire

// File: tb/tb_pmos_switch_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmos_switch_model
// Description : Scoreboard bench for pmos_switch_model. A debug instance and a
//               non-debug instance see identical stimulus; expected responses
//               come from a reference model and are queued for the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmos_switch_model;

  typedef struct packed {
    logic [1:0]  d;
    logic        drv;
    logic        berr;
    logic        xerr;
    logic [31:0] on;
    logic [31:0] tog;
  } exp_t;

  logic clk;
  logic reset;
  pmos_switch_model_if bus_a ();
  pmos_switch_model_if bus_b ();

  pmos_switch_model #(.DEBUG("true"), .W(4), .L(1), .M(2), .NF(3)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  pmos_switch_model #(.DEBUG("false"), .W(2097152), .L(7), .M(2097152), .NF(2097152)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  // reference state
  logic [1:0]  m_d;
  logic [31:0] m_on, m_tog;
  logic        m_berr, m_xerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Switch behaviour: conducting passes source, off floats, unknown gate
  // corrupts anything that is actually being driven.
  function automatic logic [1:0] resolve(input logic [1:0] g, input logic [1:0] s);
    if (g == 2'b00) return s;
    if (g == 2'b01) return 2'b10;
    return (s == 2'b10) ? 2'b10 : 2'b11;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_d = 2'b10; m_on = 0; m_tog = 0; m_berr = 0; m_xerr = 0;
  endtask

  // Called at a falling edge: drive, predict, then advance to next falling edge.
  task automatic step(input logic [1:0] g, input logic [1:0] s, input logic [1:0] b, input logic clr);
    logic [1:0] nd;
    exp_t e;
    bus_a.g = g; bus_a.s = s; bus_a.bulk = b; bus_a.stat_clr = clr;
    bus_b.g = g; bus_b.s = s; bus_b.bulk = b; bus_b.stat_clr = clr;
    nd = resolve(g, s);
    if (clr) begin
      m_on = 0; m_tog = 0; m_berr = 0; m_xerr = 0;
    end else begin
      if (g == 2'b00) m_on = sat_inc(m_on);
      if (nd != m_d)  m_tog = sat_inc(m_tog);
      if (b != 2'b01) m_berr = 1'b1;
      if (nd == 2'b11) m_xerr = 1'b1;
    end
    m_d = nd;
    e.d = nd; e.drv = (nd != 2'b10); e.berr = m_berr; e.xerr = m_xerr;
    e.on = m_on; e.tog = m_tog;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_d"},     {62'd0, bus_a.d}, 64'h2);
    chk({tag, "_drv"},   {63'd0, bus_a.d_drive}, 64'h0);
    chk({tag, "_berr"},  {63'd0, bus_a.bulk_err}, 64'h0);
    chk({tag, "_xerr"},  {63'd0, bus_a.x_err}, 64'h0);
    chk({tag, "_on"},    {32'd0, bus_a.stat_on}, 64'h0);
    chk({tag, "_tog"},   {32'd0, bus_a.stat_tog}, 64'h0);
    chk({tag, "_b_d"},   {62'd0, bus_b.d}, 64'h2);
  endtask

  // Monitor: every rising edge presents a new output; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_d",    {62'd0, bus_a.d},        {62'd0, e.d});
        chk("a_drv",  {63'd0, bus_a.d_drive},  {63'd0, e.drv});
        chk("a_berr", {63'd0, bus_a.bulk_err}, {63'd0, e.berr});
        chk("a_xerr", {63'd0, bus_a.x_err},    {63'd0, e.xerr});
        chk("a_on",   {32'd0, bus_a.stat_on},  {32'd0, e.on});
        chk("a_tog",  {32'd0, bus_a.stat_tog}, {32'd0, e.tog});
        chk("b_d",    {62'd0, bus_b.d},        {62'd0, e.d});
        chk("b_drv",  {63'd0, bus_b.d_drive},  {63'd0, e.drv});
        chk("b_stat", {bus_b.stat_on, bus_b.stat_tog}, 64'h0);
        chk("b_flag", {62'd0, bus_b.bulk_err, bus_b.x_err}, 64'h0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus_a.g = 2'b01; bus_a.s = 2'b00; bus_a.bulk = 2'b01; bus_a.stat_clr = 1'b0;
    bus_b.g = 2'b01; bus_b.s = 2'b00; bus_b.bulk = 2'b01; bus_b.stat_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    chk("weff_a", bus_a.weff, 64'd24);
    chk("weff_b", bus_b.weff, 64'h8000_0000_0000_0000);
    reset = 1'b0;

    // conducting 1 for three cycles
    repeat (3) step(2'b00, 2'b01, 2'b01, 1'b0);
    // gate off
    repeat (3) step(2'b01, 2'($urandom_range(0, 3)), 2'b01, 1'b0);
    // unknown gate with driven source, then floating source
    step(2'b11, 2'b00, 2'b01, 1'b0);
    step(2'b10, 2'b10, 2'b01, 1'b0);
    step(2'b10, 2'b10, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b01, 1'b1);
    // bulk glitch, then clear while conducting
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b1);
    step(2'b00, 2'b01, 2'b01, 1'b0);

    // counters near their ceiling
    force dut_a.stat_on_q = 32'hFFFF_FFFE;
    force dut_a.stat_tog_q = 32'hFFFF_FFFE;
    #1;
    release dut_a.stat_on_q;
    release dut_a.stat_tog_q;
    m_on = 32'hFFFF_FFFE;
    m_tog = 32'hFFFF_FFFE;
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01,
           ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("arst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(2'b00, 2'b00, 2'b01, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01,
           ($urandom_range(0, 15) == 0));
    end

    @(posedge clk);
    #2;
    chk("drain", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmos_switch_model.md
# pmos_switch_model

Clocked, synthesizable behavioural model of a single PMOS pass transistor for switch-level netlist emulation. Each cycle it samples gate, source and bulk as encoded 4-state values and registers the resolved drain value, a drive-enable and diagnostics. Device geometry is carried as parameters and reported on an effective-width output. Diagnostic counters are present when `DEBUG` is "true".

## Interface
- `DEBUG`, "true": "true" enables counters and the `stat_*` outputs; any other value ties the counters to 0.
- `W`, 0: device width in integer units (32-bit unsigned).
- `L`, 0: device length in integer units (32-bit unsigned); reported only.
- `M`, 0: multiplier (32-bit unsigned).
- `NF`, 0: number of fingers (32-bit unsigned).
- `clk`  in  1  sampling clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `g`  in  2  gate, encoded: 00=0, 01=1, 10=Z, 11=X.
- `s`  in  2  source, same encoding.
- `bulk`  in  2  body terminal, same encoding.
- `stat_clr`  in  1  synchronous clear of counters and sticky flags.
- `d`  out  2  registered drain value, same encoding.
- `d_drive`  out  1  registered; 1 when `d` is not Z.
- `weff`  out  64  constant W×M×NF; combinational, unaffected by reset.
- `bulk_err`  out  1  sticky; bulk sampled as anything other than 1.
- `x_err`  out  1  sticky; `d` resolved to X.
- `stat_on`  out  32  cycles with the channel conducting (g sampled as 0).
- `stat_tog`  out  32  number of cycles in which the registered `d` changed value.

## Operation
- Resolution per cycle from sampled g, s:
  - g=0: d=s. Z source gives Z.
  - g=1: d=Z.
  - g=X or Z: d=Z if s=Z, otherwise d=X. The L/H weak states are collapsed to X.
- `d_drive` = (next d != Z), registered together with `d`.
- `bulk_err` sets on any cycle where bulk != 01; it stays set until reset or `stat_clr`.
- `x_err` sets on any cycle where the next d = 11; same clearing rules as `bulk_err`.
- `stat_on` increments when g=00. It saturates at 0xFFFFFFFF and does not wrap.
- `stat_tog` increments when the next d differs from the current d. It saturates at 0xFFFFFFFF.
- `stat_clr` has priority over the same-cycle increment and flag set: the result is 0, not 1.
- DEBUG != "true": `stat_on`, `stat_tog`, `bulk_err` and `x_err` are constant 0. `d` and `d_drive` still function.
- `weff` is computed in 64 bits with no overflow for 32-bit operands up to 2^21 each. Wider products truncate to the low 64 bits.

## Timing
- Latency: 1 clock from the input sample to `d`/`d_drive`.
- Reset (asynchronous assert; deassert sampled on `clk`):
  - `d`=10 (Z), `d_drive`=0.
  - `bulk_err`=0, `x_err`=0, `stat_on`=0, `stat_tog`=0.
- Reset during operation takes effect immediately, without waiting for `clk`.
- First sample after reset deasserts: the toggle compare is against Z. A first resolved value of 0 therefore counts as one toggle.
- No handshake: inputs are sampled every cycle.

## Test plan
- Reset, then g=00, s=01, bulk=01 for 3 cycles -> `d`=01 and `d_drive`=1 from cycle 1; `stat_on`=3, `stat_tog`=1, both flags 0.
- g=01 with any s -> `d`=10 and `d_drive`=0 one cycle later; `stat_on` does not advance.
- g=11, s=00 -> `d`=11 and `x_err`=1. Then g=10, s=10 -> `d`=10; `x_err` remains 1 until `stat_clr`.
- bulk=00 for one cycle, then bulk=01 -> `bulk_err`=1 and held. `stat_clr`, asserted in a cycle where g=00, gives `stat_on`=0 and `bulk_err`=0 the following cycle.
- Preload `stat_on` to 0xFFFFFFFE via a long run (or a forced state), then 3 more conducting cycles -> `stat_on` stays at 0xFFFFFFFF.
- Parameters W=4, M=2, NF=3 -> `weff`=24. With DEBUG="false", all `stat_*` outputs and both flags read 0 under the previous stimuli.
